ring_buffer_arbiter: RTL and testbench
======================================

// Module: ring_buffer_arbiter
// PURPOSE
//  Shares one Ring_Buffer instance between NUM_REQ requesters with round-robin arbitration.
//  Each request is a read or a write. Drives the buffer's mode/WData, routes RData back, and masks illegal ops.
//  A flush sequencer drains the buffer on command.
//  Sits between client engines and the buffer; one buffer op per clk.
// PARAMETERS
//  NUM_REQ    4  number of requesters (2..8)
//  REG_WIDTH  8  data width; must match the buffer
//  PTR_SIZE   3  buffer pointer width; buffer depth = 1<<PTR_SIZE
// PORTS
//  clk          in   1                  clock
//  reset_n      in   1                  async reset, active-low
//  req_valid    in   NUM_REQ            per-requester request
//  req_write    in   NUM_REQ            1=write, 0=read, per requester
//  req_wdata    in   NUM_REQ*REG_WIDTH  write data; requester i uses [i*REG_WIDTH +: REG_WIDTH]
//  req_ready    out  NUM_REQ            one-hot grant, combinational; txn done when valid&ready
//  rsp_valid    out  NUM_REQ            one-hot read-data strobe, registered
//  rsp_data     out  REG_WIDTH          read data, valid while any rsp_valid
//  flush_req    in   1                  pulse: drain buffer
//  flush_busy   out  1                  high while flushing
//  buf_mode     out  2                  to buffer: 00 idle, 01 read, 10 write
//  buf_wdata    out  REG_WIDTH          to buffer WData
//  buf_rdata    in   REG_WIDTH          from buffer RData
//  buf_empty    in   1                  from buffer isEmpty
//  buf_full     in   1                  from buffer isFull
// BEHAVIOUR
//  Reset: state=ARB, rr_ptr=0, rsp_valid=0, flush_busy=0; req_ready=0 and buf_mode=00 follow from state.
//  Eligibility:
//   - eligible[i] = req_valid[i] & (req_write[i] ? !buf_full : !buf_empty).
//   - Ineligible requests are held, never dropped.
//  ARB state:
//   - Grant the first eligible index at or after rr_ptr (wrapping modulo NUM_REQ).
//   - req_ready[g]=1. buf_mode = write ? 10 : 01. buf_wdata = slice g; else 0.
//   - On grant, rr_ptr <= (g+1) mod NUM_REQ. No grant: buf_mode=00, rr_ptr holds.
//  Read response:
//   - Read granted in cycle N gives rsp_valid[g]=1 in cycle N+1, with rsp_data=buf_rdata.
//   - rsp_data = 0 when no rsp_valid.
//   - Back-to-back reads are allowed; a response every cycle.
//  Full/empty:
//   - Flags are sampled combinationally each cycle. Pointer updates land at the edge, so the next cycle sees fresh flags.
//   - No over-write or under-read is ever issued.
//  Mixed read/write contention resolves by round-robin only; no read/write priority.
//  FSM:
//   - ARB: on flush_req -> FLUSH. Requests in that same cycle are still arbitrated.
//   - FLUSH: req_ready=0, flush_busy=1. buf_mode=01 while !buf_empty; no rsp_valid for flushed data.
//   - FLUSH: on buf_empty -> ARB with buf_mode=00 that cycle. flush_req while in FLUSH is ignored.
//   - Flushing an empty buffer takes exactly 1 cycle in FLUSH.
//  Reset mid-op: everything returns to reset values immediately; a pending rsp_valid is dropped.
// CONFIGURATION
//  RB_ARB_STATS_EN defined:
//   - Adds out stat_grants [NUM_REQ*16]: per-requester saturating 16-bit grant counters.
//   - Adds out stat_stalls [16]: saturating count of cycles with req_valid!=0 and no grant (ARB only).
//   - All counters clear on reset.
//  Macro undefined: the ports and counters are absent; core behaviour is identical.
// STRUCTURE
//  Package rb_arb_pkg:
//   - MODE_IDLE=2'b00, MODE_R=2'b01, MODE_W=2'b10 (shared with Ring_Buffer users).
//   - typedef enum {ARB, FLUSH} arb_state_t.
//  Sub-module rr_pick:
//   - Combinational round-robin picker: in req[NUM_REQ], ptr.
//   - Out gnt_onehot, gnt_idx, any.
//   - Top holds the FSM, rr_ptr, the response pipe and stats.
// TESTING (NUM_REQ=4, REG_WIDTH=8, PTR_SIZE=3)
//  1. All 4 write 0x10+i each cycle, after reset ->
//     - grants 0,1,2,3,0,... one per cycle.
//     - after 8 grants buf_full=1 and req_ready stays 0.
//  2. Full buffer; req0 read, req1 write 0xAA in the same cycle ->
//     - read granted first; rsp_valid[0] next cycle with 0x10.
//     - write granted the following cycle.
//  3. Empty buffer; req2 read held 5 cycles ->
//     - req_ready stays 0 and buf_mode=00.
//     - req3 writes 0x55 -> req2 granted the next cycle, rsp_data=0x55.
//  4. 5 entries, flush_req pulse ->
//     - flush_busy high for 6 cycles with 5 buf_mode=01 cycles.
//     - no rsp_valid; then ARB and buf_empty=1.
//  5. Reset asserted the cycle after a read grant -> rsp_valid never rises; all outputs at reset values.
//  6. RB_ARB_STATS_EN: scenario 1 ->
//     - stat_grants = {2,2,2,2} for requesters 3..0.
//     - stat_stalls increments each full cycle.

Source files
------------

// File: rtl/rb_arb_pkg.sv
// Shared constants and types for the ring-buffer arbiter.
package rb_arb_pkg;

  localparam logic [1:0] MODE_IDLE = 2'b00;
  localparam logic [1:0] MODE_R    = 2'b01;
  localparam logic [1:0] MODE_W    = 2'b10;

  localparam int unsigned STAT_WIDTH = 16;

  typedef enum logic {
    ARB   = 1'b0,
    FLUSH = 1'b1
  } arb_state_t;

  // Index width for n requesters; at least one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ring_buffer_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick
  import rb_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt_onehot,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               any
);

  logic [31:0] idx;

  // Scan from ptr, wrapping modulo NUM_REQ; first hit wins.
  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    idx        = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 32'(ptr) + 32'(k);
      if (idx >= 32'(NUM_REQ)) idx = idx - 32'(NUM_REQ);
      if (!any && req[idx[IDX_W-1:0]]) begin
        any     = 1'b1;
        gnt_idx = idx[IDX_W-1:0];
      end
    end
    if (any) gnt_onehot[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/ring_buffer_arbiter.sv
// Round-robin arbiter sharing one ring buffer between NUM_REQ requesters,
// with a flush sequencer. Optional statistics under RB_ARB_STATS_EN.
module ring_buffer_arbiter
  import rb_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned REG_WIDTH = 8,
  parameter int unsigned PTR_SIZE  = 3
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_write,
  input  logic [NUM_REQ*REG_WIDTH-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [REG_WIDTH-1:0]           rsp_data,
  input  logic                           flush_req,
  output logic                           flush_busy,
  output logic [1:0]                     buf_mode,
  output logic [REG_WIDTH-1:0]           buf_wdata,
  input  logic [REG_WIDTH-1:0]           buf_rdata,
  input  logic                           buf_empty,
  input  logic                           buf_full
`ifdef RB_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STAT_WIDTH-1:0]  stat_grants,
  output logic [STAT_WIDTH-1:0]          stat_stalls
`endif
);

  localparam int unsigned IDX_W = idx_width(NUM_REQ);

  // Reject unsupported configurations at elaboration.
  generate
    if (NUM_REQ < 2 || NUM_REQ > 8 || PTR_SIZE < 1) begin : g_bad_cfg
      $error("ring_buffer_arbiter: unsupported NUM_REQ/PTR_SIZE");
    end
  endgenerate

  arb_state_t         state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   ptr_next;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] pick_req;
  logic [NUM_REQ-1:0] gnt_onehot;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_any;
  logic               gnt_write;

  // A request may go only if the buffer can take it this cycle.
  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      eligible[i] = req_valid[i] & (req_write[i] ? ~buf_full : ~buf_empty);
    end
  end

  assign pick_req  = (state == ARB) ? eligible : '0;
  assign gnt_write = |(gnt_onehot & req_write);
  assign ptr_next  = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req        (pick_req),
    .ptr        (rr_ptr),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .any        (gnt_any)
  );

  // Grant, buffer command and write-data steering for the current cycle.
  always_comb begin
    req_ready = '0;
    buf_mode  = MODE_IDLE;
    buf_wdata = '0;
    case (state)
      ARB: begin
        if (gnt_any) begin
          req_ready = gnt_onehot;
          buf_mode  = gnt_write ? MODE_W : MODE_R;
          for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt_onehot[i] && gnt_write) buf_wdata = req_wdata[i*REG_WIDTH +: REG_WIDTH];
          end
        end
      end
      FLUSH: begin
        if (!buf_empty) buf_mode = MODE_R;
      end
      default: ;
    endcase
  end

  // Read data is only presented alongside its strobe.
  assign rsp_data = (|rsp_valid) ? buf_rdata : '0;

  // FSM, round-robin pointer and read-response strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ARB;
      rr_ptr     <= '0;
      rsp_valid  <= '0;
      flush_busy <= 1'b0;
    end else begin
      case (state)
        ARB: begin
          if (gnt_any) rr_ptr <= ptr_next;
          rsp_valid <= (gnt_any && !gnt_write) ? gnt_onehot : '0;
          if (flush_req) begin
            state      <= FLUSH;
            flush_busy <= 1'b1;
          end
        end
        FLUSH: begin
          rsp_valid <= '0;
          if (buf_empty) begin
            state      <= ARB;
            flush_busy <= 1'b0;
          end
        end
        default: begin
          state <= ARB;
        end
      endcase
    end
  end

`ifdef RB_ARB_STATS_EN
  logic stall_c;
  assign stall_c = (state == ARB) && (|req_valid) && !gnt_any;

  // Saturating per-requester grant counters and stall counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_grants <= '0;
      stat_stalls <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (gnt_onehot[i] && (stat_grants[i*STAT_WIDTH +: STAT_WIDTH] != '1)) begin
          stat_grants[i*STAT_WIDTH +: STAT_WIDTH] <=
            stat_grants[i*STAT_WIDTH +: STAT_WIDTH] + STAT_WIDTH'(1);
        end
      end
      if (stall_c && (stat_stalls != '1)) stat_stalls <= stat_stalls + STAT_WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_ring_buffer_arbiter.sv
// Self-checking bench for ring_buffer_arbiter with a queue-based buffer stand-in
// and a transaction-level reference model. Stats checks active under RB_ARB_STATS_EN.
module tb_ring_buffer_arbiter;

  localparam int N = 4;
  localparam int W = 8;
  localparam int D = 8;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [N-1:0]   req_valid, req_write, req_ready, rsp_valid;
  logic [N*W-1:0] req_wdata;
  logic [W-1:0]   rsp_data, buf_wdata, buf_rdata;
  logic           flush_req, flush_busy, buf_empty, buf_full;
  logic [1:0]     buf_mode;
`ifdef RB_ARB_STATS_EN
  logic [N*16-1:0] stat_grants;
  logic [15:0]     stat_stalls;
`endif

  always #5 clk = ~clk;

  ring_buffer_arbiter #(.NUM_REQ(N), .REG_WIDTH(W), .PTR_SIZE(3)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_write(req_write), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .flush_req(flush_req), .flush_busy(flush_busy),
    .buf_mode(buf_mode), .buf_wdata(buf_wdata), .buf_rdata(buf_rdata),
    .buf_empty(buf_empty), .buf_full(buf_full)
`ifdef RB_ARB_STATS_EN
    , .stat_grants(stat_grants), .stat_stalls(stat_stalls)
`endif
  );

  // Buffer stand-in: depth-8 FIFO, RData registered on read.
  logic [W-1:0] bq[$];
  int           bcount;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bq.delete();
      bcount    <= 0;
      buf_rdata <= '0;
    end else begin
      if (buf_mode == 2'b10 && bq.size() < D) bq.push_back(buf_wdata);
      else if (buf_mode == 2'b01 && bq.size() > 0) buf_rdata <= bq.pop_front();
      bcount <= bq.size();
    end
  end
  assign buf_empty = (bcount == 0);
  assign buf_full  = (bcount == D);

  // Reference model state.
  int           m_ptr;
  bit           m_flush;
  logic [N-1:0] m_rsp_v;
  logic [W-1:0] m_rsp_d;
  logic [W-1:0] mq[$];

  // Per-cycle snapshot: observed and expected.
  logic [N-1:0] o_ready, e_ready, o_rsp_v, e_rsp_v;
  logic [1:0]   o_mode, e_mode;
  logic [W-1:0] o_wdata, e_wdata, o_rsp_d, e_rsp_d;
  logic         o_busy, e_busy;
  int           g_obs, g_exp;

  int n_checks = 0;
  int n_pass   = 0;

  function automatic void model_reset();
    m_ptr = 0; m_flush = 0; m_rsp_v = '0; m_rsp_d = '0; mq.delete();
  endfunction

  // One clock: snapshot DUT at mid-cycle, predict from the model, advance both.
  task automatic step();
    int g;
    logic [N-1:0] n_rsp_v;
    logic [W-1:0] n_rsp_d;
    bit n_flush;
    int n_ptr;
    @(negedge clk); #1;
    o_ready = req_ready; o_mode = buf_mode; o_wdata = buf_wdata;
    o_rsp_v = rsp_valid; o_rsp_d = rsp_data; o_busy = flush_busy;
    e_busy  = m_flush; e_rsp_v = m_rsp_v; e_rsp_d = (m_rsp_v != '0) ? m_rsp_d : '0;
    e_ready = '0; e_mode = 2'b00; e_wdata = '0; g = -1;
    n_rsp_v = '0; n_rsp_d = '0; n_flush = m_flush; n_ptr = m_ptr;
    if (!m_flush) begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_ptr + k) % N;
        if (g < 0 && req_valid[i] && (req_write[i] ? (mq.size() < D) : (mq.size() > 0))) g = i;
      end
      if (g >= 0) begin
        e_ready[g] = 1'b1;
        n_ptr = (g + 1) % N;
        if (req_write[g]) begin
          e_mode = 2'b10; e_wdata = req_wdata[g*W +: W]; mq.push_back(e_wdata);
        end else begin
          e_mode = 2'b01; n_rsp_v[g] = 1'b1; n_rsp_d = mq.pop_front();
        end
      end
      if (flush_req) n_flush = 1;
    end else if (mq.size() != 0) begin
      e_mode = 2'b01; void'(mq.pop_front());
    end else begin
      n_flush = 0;
    end
    g_exp = g;
    g_obs = -1;
    for (int i = 0; i < N; i++) if (o_ready[i]) g_obs = i;
    @(posedge clk); #1;
    m_rsp_v = n_rsp_v; m_rsp_d = n_rsp_d; m_flush = n_flush; m_ptr = n_ptr;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req_valid = '0; req_write = '0; req_wdata = '0; flush_req = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    n_checks++;
    if ({req_ready, buf_mode, buf_wdata, rsp_valid, rsp_data, flush_busy} !== 27'd0)
      $display("FAIL reset_values: got %h want 0", {req_ready, buf_mode, buf_wdata, rsp_valid, rsp_data, flush_busy});
    else n_pass++;
    reset_n = 1'b1;
    step();
    n_checks++;
    if ({o_ready, o_mode, o_wdata, o_rsp_v, o_rsp_d, o_busy} !== {e_ready, e_mode, e_wdata, e_rsp_v, e_rsp_d, e_busy})
      $display("FAIL reset_idle: got %h want %h", {o_ready, o_mode, o_wdata, o_rsp_v, o_rsp_d, o_busy}, {e_ready, e_mode, e_wdata, e_rsp_v, e_rsp_d, e_busy});
    else n_pass++;
  endtask

  task automatic test_fill();
    req_valid = 4'hF; req_write = 4'hF; req_wdata = {8'h13, 8'h12, 8'h11, 8'h10};
    for (int c = 0; c < 12; c++) begin
      step();
      n_checks++;
      if ({o_ready, o_mode, o_wdata, o_rsp_v, o_rsp_d, o_busy} !== {e_ready, e_mode, e_wdata, e_rsp_v, e_rsp_d, e_busy})
        $display("FAIL fill_model c%0d: got %h want %h", c, {o_ready, o_mode, o_wdata, o_rsp_v, o_rsp_d, o_busy}, {e_ready, e_mode, e_wdata, e_rsp_v, e_rsp_d, e_busy});
      else n_pass++;
      n_checks++;
      if (c < 8) begin
        if (g_obs !== c % 4) $display("FAIL fill_grant c%0d: got %0d want %0d", c, g_obs, c % 4);
        else n_pass++;
      end else begin
        if ({o_ready, o_mode} !== 6'd0) $display("FAIL full_stall c%0d: got %h want 0", c, {o_ready, o_mode});
        else n_pass++;
      end
    end
    req_valid = '0;
`ifdef RB_ARB_STATS_EN
    n_checks++;
    if (stat_grants !== {16'd2, 16'd2, 16'd2, 16'd2}) $display("FAIL stat_grants: got %h want 0002000200020002", stat_grants);
    else n_pass++;
    n_checks++;
    if (stat_stalls !== 16'd4) $display("FAIL stat_stalls: got %0d want 4", stat_stalls);
    else n_pass++;
`endif
  endtask

  task automatic test_contention();
    req_valid = 4'b0011; req_write = 4'b0010; req_wdata = {8'h00, 8'h00, 8'hAA, 8'h00};
    step();
    n_checks++;
    if (g_obs !== 0) $display("FAIL cont_read_first: got %0d want 0", g_obs);
    else n_pass++;
    req_valid = 4'b0010;
    step();
    n_checks++;
    if ({g_obs, o_rsp_v, o_rsp_d} !== {32'sd1, 4'b0001, 8'h10})
      $display("FAIL cont_write_next: got g=%0d v=%b d=%h want g=1 v=0001 d=10", g_obs, o_rsp_v, o_rsp_d);
    else n_pass++;
    req_valid = '0;
    step();
    n_checks++;
    if ({o_ready, o_mode, o_wdata, o_rsp_v, o_rsp_d, o_busy} !== {e_ready, e_mode, e_wdata, e_rsp_v, e_rsp_d, e_busy})
      $display("FAIL cont_model: got %h want %h", {o_ready, o_mode, o_wdata, o_rsp_v, o_rsp_d, o_busy}, {e_ready, e_mode, e_wdata, e_rsp_v, e_rsp_d, e_busy});
    else n_pass++;
  endtask

  task automatic test_flush();
    int busy, rd;
    bit rsp_seen, done;
    req_valid = 4'b0001; req_write = '0;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) req_valid = '0;
      step();
      n_checks++;
      if ({o_ready, o_mode, o_wdata, o_rsp_v, o_rsp_d, o_busy} !== {e_ready, e_mode, e_wdata, e_rsp_v, e_rsp_d, e_busy})
        $display("FAIL drain3 c%0d: got %h want %h", c, {o_ready, o_mode, o_wdata, o_rsp_v, o_rsp_d, o_busy}, {e_ready, e_mode, e_wdata, e_rsp_v, e_rsp_d, e_busy});
      else n_pass++;
    end
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    busy = 0; rd = 0; rsp_seen = 0; done = 0;
    for (int c = 0; c < 20; c++) begin
      flush_req = (c == 2);
      step();
      n_checks++;
      if ({o_ready, o_mode, o_wdata, o_rsp_v, o_rsp_d, o_busy} !== {e_ready, e_mode, e_wdata, e_rsp_v, e_rsp_d, e_busy})
        $display("FAIL flush_model c%0d: got %h want %h", c, {o_ready, o_mode, o_wdata, o_rsp_v, o_rsp_d, o_busy}, {e_ready, e_mode, e_wdata, e_rsp_v, e_rsp_d, e_busy});
      else n_pass++;
      if (o_busy) busy++;
      if (o_busy && o_mode == 2'b01) rd++;
      if (o_rsp_v != '0) rsp_seen = 1;
      if (busy > 0 && !o_busy) begin done = 1; break; end
    end
    flush_req = 1'b0;
    n_checks++;
    if (!done) $display("FAIL flush_timeout: got busy=%0d after 20 cycles want completion", busy);
    else n_pass++;
    n_checks++;
    if ({busy, rd, 31'd0, rsp_seen, 31'd0, buf_empty} !== {32'sd6, 32'sd5, 31'd0, 1'b0, 31'd0, 1'b1})
      $display("FAIL flush_counts: got busy=%0d rd=%0d rsp=%0d empty=%0d want 6 5 0 1", busy, rd, rsp_seen, buf_empty);
    else n_pass++;
    // Flushing an already empty buffer: one FLUSH cycle, no reads.
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    step();
    n_checks++;
    if ({o_busy, o_mode} !== 3'b100) $display("FAIL flush_empty_cycle: got busy=%b mode=%b want 1 00", o_busy, o_mode);
    else n_pass++;
    step();
    n_checks++;
    if (o_busy !== 1'b0) $display("FAIL flush_empty_done: got busy=%b want 0", o_busy);
    else n_pass++;
  endtask

  task automatic test_empty_hold();
    req_valid = 4'b0100; req_write = '0; req_wdata = {8'h55, 24'h0};
    for (int c = 0; c < 5; c++) begin
      step();
      n_checks++;
      if ({o_ready, o_mode} !== 6'd0) $display("FAIL empty_hold c%0d: got %h want 0", c, {o_ready, o_mode});
      else n_pass++;
    end
    req_valid = 4'b1100; req_write = 4'b1000;
    step();
    n_checks++;
    if ({g_obs, o_mode, o_wdata} !== {32'sd3, 2'b10, 8'h55}) $display("FAIL empty_write: got g=%0d mode=%b wd=%h want 3 10 55", g_obs, o_mode, o_wdata);
    else n_pass++;
    req_valid = 4'b0100;
    step();
    n_checks++;
    if (g_obs !== 2) $display("FAIL empty_read_grant: got %0d want 2", g_obs);
    else n_pass++;
    req_valid = '0;
    step();
    n_checks++;
    if ({o_rsp_v, o_rsp_d} !== {4'b0100, 8'h55}) $display("FAIL empty_read_data: got v=%b d=%h want 0100 55", o_rsp_v, o_rsp_d);
    else n_pass++;
  endtask

  task automatic test_reset_midop();
    req_valid = 4'b1000; req_write = 4'b1000; req_wdata = {8'h77, 24'h0};
    step();
    req_valid = 4'b0001; req_write = '0;
    @(negedge clk); #1;
    n_checks++;
    if (req_ready !== 4'b0001) $display("FAIL midop_grant: got %b want 0001", req_ready);
    else n_pass++;
    reset_n = 1'b0; req_valid = '0;
    model_reset();
    @(posedge clk); #1;
    n_checks++;
    if (rsp_valid !== '0) $display("FAIL midop_rsp_dropped: got %b want 0000", rsp_valid);
    else n_pass++;
    @(negedge clk); #1;
    n_checks++;
    if ({req_ready, buf_mode, buf_wdata, rsp_valid, rsp_data, flush_busy} !== 27'd0)
      $display("FAIL midop_reset_values: got %h want 0", {req_ready, buf_mode, buf_wdata, rsp_valid, rsp_data, flush_busy});
    else n_pass++;
    reset_n = 1'b1;
    step();
    n_checks++;
    if ({o_ready, o_mode, o_wdata, o_rsp_v, o_rsp_d, o_busy} !== {e_ready, e_mode, e_wdata, e_rsp_v, e_rsp_d, e_busy})
      $display("FAIL midop_after: got %h want %h", {o_ready, o_mode, o_wdata, o_rsp_v, o_rsp_d, o_busy}, {e_ready, e_mode, e_wdata, e_rsp_v, e_rsp_d, e_busy});
    else n_pass++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 500; c++) begin
      req_valid = N'($urandom);
      req_write = N'($urandom);
      req_wdata = (N*W)'($urandom);
      flush_req = ($urandom_range(0, 31) == 0);
      step();
      n_checks++;
      if ({o_ready, o_mode, o_wdata, o_rsp_v, o_rsp_d, o_busy} !== {e_ready, e_mode, e_wdata, e_rsp_v, e_rsp_d, e_busy})
        $display("FAIL random c%0d: got %h want %h", c, {o_ready, o_mode, o_wdata, o_rsp_v, o_rsp_d, o_busy}, {e_ready, e_mode, e_wdata, e_rsp_v, e_rsp_d, e_busy});
      else n_pass++;
    end
    req_valid = '0; flush_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_contention();
    test_flush();
    test_empty_hold();
    test_reset_midop();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000 want finish");
    $fatal(1);
  end

endmodule
